// File: rtl/gpu_instruction_dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher: field widths, opcodes,
// engine indices, FSM state encoding and the opcode-to-engine decode.
package gpu_instruction_dispatcher_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_CLEAR     = 4'h1;
  localparam logic [3:0] OP_FILL_RECT = 4'h2;
  localparam logic [3:0] OP_DRAW_LINE = 4'h4;
  localparam logic [3:0] OP_DRAW_ARC  = 4'h8;

  localparam int ENG_CLEAR     = 0;
  localparam int ENG_FILL_RECT = 1;
  localparam int ENG_DRAW_LINE = 2;
  localparam int ENG_DRAW_ARC  = 3;
  localparam int NUM_ENGINES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  // One-hot engine select for a draw opcode; zero for NOP and illegal codes.
  function automatic logic [NUM_ENGINES-1:0] engine_mask(input logic [3:0] op);
    logic [NUM_ENGINES-1:0] mask;
    mask = '0;
    case (op)
      OP_CLEAR:     mask[ENG_CLEAR]     = 1'b1;
      OP_FILL_RECT: mask[ENG_FILL_RECT] = 1'b1;
      OP_DRAW_LINE: mask[ENG_DRAW_LINE] = 1'b1;
      OP_DRAW_ARC:  mask[ENG_DRAW_ARC]  = 1'b1;
      default:      mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/gpu_instruction_dispatcher_watchdog.sv
// Saturating wait-cycle counter; expired flags the last allowed WAIT cycle.
module gpu_watchdog_counter #(
  parameter int CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg >= LAST);

endmodule

// File: rtl/gpu_instruction_dispatcher.sv
// Pops instructions from the FIFO head, latches the fields, and issues each
// draw opcode to its engine, waiting for completion under a watchdog.
module gpu_instruction_dispatcher
  import gpu_instruction_dispatcher_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic [2:0]              quad_i,
  output logic                    pop_instruction_o,
  output logic [3:0]              opcode_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [2:0]              quad_o,
  output logic [3:0]              start_o,
  input  logic [3:0]              engine_done_i,
  output logic                    busy_o,
  output logic                    illegal_op_o,
  output logic                    timeout_o
);

  state_t state_reg, state_next;
  logic [NUM_ENGINES-1:0] cur_mask;
  logic done_match;
  logic wd_clear, wd_enable, wd_expired;

  assign cur_mask   = engine_mask(opcode_o);
  assign done_match = |(engine_done_i & cur_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    pop_instruction_o = 1'b0;
    start_o           = '0;
    illegal_op_o      = 1'b0;
    timeout_o         = 1'b0;
    wd_clear          = 1'b0;
    wd_enable         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty_i) begin
          pop_instruction_o = 1'b1;
          state_next        = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode_o == OP_NOP) begin
          state_next = ST_IDLE;
        end else if (cur_mask == '0) begin
          illegal_op_o = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_o    = cur_mask;
        wd_clear   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over a watchdog expiry landing in the same cycle.
        if (done_match) begin
          state_next = ST_IDLE;
        end else if (wd_expired) begin
          timeout_o  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          wd_enable = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Strobes are Mealy outputs, so they must be masked while reset is held.
    if (rst) begin
      state_next        = ST_IDLE;
      pop_instruction_o = 1'b0;
      start_o           = '0;
      illegal_op_o      = 1'b0;
      timeout_o         = 1'b0;
      wd_clear          = 1'b0;
      wd_enable         = 1'b0;
    end
  end

  assign busy_o = (state_reg != ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_o <= '0;
      x1_o     <= '0;
      y1_o     <= '0;
      x2_o     <= '0;
      y2_o     <= '0;
      rad_o    <= '0;
      r_o      <= '0;
      g_o      <= '0;
      b_o      <= '0;
      quad_o   <= '0;
    end else if (pop_instruction_o) begin
      opcode_o <= opcode_i;
      x1_o     <= x1_i;
      y1_o     <= y1_i;
      x2_o     <= x2_i;
      y2_o     <= y2_i;
      rad_o    <= rad_i;
      r_o      <= r_i;
      g_o      <= g_i;
      b_o      <= b_i;
      quad_o   <= quad_i;
    end
  end

  gpu_watchdog_counter #(
    .CYCLES(WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

endmodule

// File: tb/tb_gpu_instruction_dispatcher.sv
// Directed bench for the instruction dispatcher with a 16-cycle watchdog.
module tb_gpu_instruction_dispatcher;
  import gpu_instruction_dispatcher_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic fifo_empty_i;
  logic [3:0] opcode_i;
  logic [WIDTH_BITS-1:0] x1_i, x2_i, rad_i;
  logic [HEIGHT_BITS-1:0] y1_i, y2_i;
  logic [CHANNEL_BITS-1:0] r_i, g_i, b_i;
  logic [2:0] quad_i;
  logic pop_instruction_o;
  logic [3:0] opcode_o;
  logic [WIDTH_BITS-1:0] x1_o, x2_o, rad_o;
  logic [HEIGHT_BITS-1:0] y1_o, y2_o;
  logic [CHANNEL_BITS-1:0] r_o, g_o, b_o;
  logic [2:0] quad_o;
  logic [3:0] start_o;
  logic [3:0] engine_done_i;
  logic busy_o, illegal_op_o, timeout_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gpu_instruction_dispatcher #(.WATCHDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty_i),
    .opcode_i(opcode_i), .x1_i(x1_i), .x2_i(x2_i), .rad_i(rad_i),
    .y1_i(y1_i), .y2_i(y2_i), .r_i(r_i), .g_i(g_i), .b_i(b_i), .quad_i(quad_i),
    .pop_instruction_o(pop_instruction_o), .opcode_o(opcode_o),
    .x1_o(x1_o), .y1_o(y1_o), .x2_o(x2_o), .y2_o(y2_o), .rad_o(rad_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o), .quad_o(quad_o), .start_o(start_o),
    .engine_done_i(engine_done_i), .busy_o(busy_o),
    .illegal_op_o(illegal_op_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle: inputs change 1 time unit after the rising
  // edge, and checks happen 3 units later, well before the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_head(input logic [3:0] op, input logic [WIDTH_BITS-1:0] x2,
                          input logic [HEIGHT_BITS-1:0] y2, input logic [2:0] q);
    opcode_i = op; x2_i = x2; y2_i = y2; quad_i = q;
  endtask

  initial begin
    rst = 1'b1; fifo_empty_i = 1'b0; engine_done_i = 4'b0;
    opcode_i = 4'h4; x1_i = 10'd3; x2_i = 10'd7; rad_i = 10'd5;
    y1_i = 9'd4; y2_i = 9'd6; r_i = 8'hAA; g_i = 8'h55; b_i = 8'h11; quad_i = 3'd2;

    // Reset held with a non-empty FIFO: nothing may leak out.
    next_cycle(); next_cycle(); settle();
    chk("rst_pop", pop_instruction_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_opcode", opcode_o, 0);
    chk("rst_x2", x2_o, 0);
    chk("rst_illegal_timeout", {illegal_op_o, timeout_o}, 0);

    // Empty FIFO for 20 cycles.
    next_cycle(); rst = 1'b0; fifo_empty_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk($sformatf("idle_pop_%0d", i), pop_instruction_o, 0);
      chk($sformatf("idle_start_%0d", i), start_o, 0);
      chk($sformatf("idle_busy_%0d", i), busy_o, 0);
      next_cycle();
    end

    // DRAW_LINE timing: pop N, fields N+1, start N+2, done N+5, idle N+6.
    set_head(4'h4, 10'd10, 9'd10, 3'd1); fifo_empty_i = 1'b0;
    settle();
    chk("line_pop_N", pop_instruction_o, 1);
    chk("line_busy_N", busy_o, 0);
    next_cycle(); fifo_empty_i = 1'b1; engine_done_i = 4'b0100;
    settle();
    chk("line_x2_N1", x2_o, 10);
    chk("line_y2_N1", y2_o, 10);
    chk("line_quad_N1", quad_o, 1);
    chk("line_pop_N1", pop_instruction_o, 0);
    chk("line_start_N1", start_o, 0);
    next_cycle(); engine_done_i = 4'b0;
    settle();
    chk("line_start_N2", start_o, 4'b0100);
    chk("line_busy_N2", busy_o, 1);
    next_cycle(); engine_done_i = 4'b0001;
    settle();
    chk("line_start_N3", start_o, 0);
    next_cycle(); engine_done_i = 4'b0;
    settle();
    chk("line_busy_N4_nonmatch", busy_o, 1);
    next_cycle(); engine_done_i = 4'b0100;
    settle();
    chk("line_busy_N5", busy_o, 1);
    chk("line_timeout_N5", timeout_o, 0);
    next_cycle(); engine_done_i = 4'b0;
    settle();
    chk("line_busy_N6", busy_o, 0);
    chk("line_x2_held", x2_o, 10);

    // Illegal opcode 4'h3.
    next_cycle(); set_head(4'h3, 10'd1, 9'd1, 3'd0); fifo_empty_i = 1'b0;
    settle();
    chk("ill_pop", pop_instruction_o, 1);
    next_cycle(); fifo_empty_i = 1'b1;
    settle();
    chk("ill_pulse", illegal_op_o, 1);
    chk("ill_start_dec", start_o, 0);
    chk("ill_busy_dec", busy_o, 1);
    next_cycle();
    settle();
    chk("ill_pulse_end", illegal_op_o, 0);
    chk("ill_start_after", start_o, 0);
    chk("ill_busy_after", busy_o, 0);
    chk("ill_pop_after", pop_instruction_o, 0);

    // NOP: popped, no pulses.
    next_cycle(); set_head(4'h0, 10'd2, 9'd2, 3'd0); fifo_empty_i = 1'b0;
    settle();
    chk("nop_pop", pop_instruction_o, 1);
    next_cycle(); fifo_empty_i = 1'b1;
    settle();
    chk("nop_pulses_dec", {illegal_op_o, timeout_o, start_o}, 0);
    chk("nop_busy_dec", busy_o, 1);
    next_cycle();
    settle();
    chk("nop_busy_after", busy_o, 0);
    chk("nop_start_after", start_o, 0);

    // DRAW_ARC watchdog: 16 WAIT cycles, timeout on the 16th, wrong done ignored.
    next_cycle(); set_head(4'h8, 10'd0, 9'd0, 3'd3); fifo_empty_i = 1'b0;
    settle();
    chk("arc_pop", pop_instruction_o, 1);
    next_cycle(); fifo_empty_i = 1'b1;
    next_cycle();
    settle();
    chk("arc_start", start_o, 4'b1000);
    for (int w = 1; w <= 16; w++) begin
      next_cycle(); engine_done_i = 4'b0001;
      settle();
      chk($sformatf("arc_wait%0d_timeout", w), timeout_o, (w == 16) ? 1 : 0);
      chk($sformatf("arc_wait%0d_busy", w), busy_o, 1);
    end
    next_cycle(); engine_done_i = 4'b0;
    settle();
    chk("arc_after_timeout", timeout_o, 0);
    chk("arc_after_busy", busy_o, 0);
    chk("arc_after_start", start_o, 0);

    // Four back-to-back DRAW_LINE entries, done 3 cycles after each start.
    next_cycle(); set_head(4'h4, 10'd20, 9'd20, 3'd0); fifo_empty_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("b2b%0d_pop", i), pop_instruction_o, 1);
      next_cycle();
      if (i == 3) fifo_empty_i = 1'b1;
      else set_head(4'h4, 10'd20, 9'd20, 3'(i + 1));
      settle();
      chk($sformatf("b2b%0d_quad", i), quad_o, i);
      chk($sformatf("b2b%0d_pop_dec", i), pop_instruction_o, 0);
      next_cycle();
      settle();
      chk($sformatf("b2b%0d_start", i), start_o, 4'b0100);
      next_cycle(); next_cycle(); next_cycle(); engine_done_i = 4'b0100;
      settle();
      chk($sformatf("b2b%0d_start_off", i), start_o, 0);
      next_cycle(); engine_done_i = 4'b0;
    end
    settle();
    chk("b2b_idle", busy_o, 0);
    chk("b2b_no_pop", pop_instruction_o, 0);

    // Reset during WAIT abandons the FILL_RECT; late done must not revive it.
    next_cycle(); set_head(4'h2, 10'd9, 9'd8, 3'd5); fifo_empty_i = 1'b0;
    next_cycle(); fifo_empty_i = 1'b1;
    next_cycle();
    settle();
    chk("rw_start", start_o, 4'b0010);
    next_cycle();
    settle();
    chk("rw_in_wait", busy_o, 1);
    next_cycle(); rst = 1'b1;
    settle();
    chk("rw_rst_busy", busy_o, 0);
    chk("rw_rst_timeout", timeout_o, 0);
    next_cycle();
    settle();
    chk("rw_rst_opcode", opcode_o, 0);
    chk("rw_rst_x2", x2_o, 0);
    chk("rw_rst_quad", quad_o, 0);
    next_cycle(); rst = 1'b0; engine_done_i = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("rw_post%0d_outs", i),
          {pop_instruction_o, busy_o, illegal_op_o, timeout_o, start_o}, 0);
      next_cycle(); engine_done_i = 4'b0;
    end
    fifo_empty_i = 1'b0; set_head(4'h1, 10'd0, 9'd0, 3'd0);
    settle();
    chk("rw_pop_resume", pop_instruction_o, 1);
    next_cycle(); fifo_empty_i = 1'b1;
    next_cycle();
    settle();
    chk("rw_clear_start", start_o, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=sim_time_limit expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
